// File: rtl/jedro_1_mem_arbiter.sv
// jedro_1_mem_arbiter
// Shares one single-port, byte-writable RAM with 1-cycle read latency between
// the instruction-fetch port and the load/store data port. Data normally wins;
// a saturating starvation counter lets a waiting fetch win after STARVE_LIMIT
// consecutive denied cycles. Read responses are routed back to the owner of
// the previous cycle's grant.
module jedro_1_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    input  logic [DATA_WIDTH/8-1:0] data_we_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    ram_en_o,
    output logic [DATA_WIDTH/8-1:0] ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int         BE_WIDTH   = DATA_WIDTH / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Owner of the response that appears on the cycle after a grant.
    typedef enum logic [1:0] {
        RESP_NONE  = 2'b00,
        RESP_INSTR = 2'b01,
        RESP_DATA  = 2'b10
    } resp_e;

    // Winner of the current cycle's arbitration.
    typedef enum logic [1:0] {
        GNT_NONE  = 2'b00,
        GNT_INSTR = 2'b01,
        GNT_DATA  = 2'b10
    } gnt_e;

    resp_e       resp_q;
    resp_e       resp_next_s;
    logic [3:0]  starve_q;
    logic [3:0]  starve_next_s;
    gnt_e        gnt_sel_s;
    logic        fetch_urgent_s;
    logic        instr_gnt_s;
    logic        data_gnt_s;

    logic                  ram_en_s;
    logic [BE_WIDTH-1:0]   ram_we_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;

    // Arbitration: a starved fetch first, otherwise data, otherwise fetch; nothing in reset.
    always_comb begin
        gnt_sel_s      = GNT_NONE;
        fetch_urgent_s = instr_req_i && (starve_q == STARVE_MAX);
        if (!rstn_i) begin
            gnt_sel_s = GNT_NONE;
        end else if (fetch_urgent_s) begin
            gnt_sel_s = GNT_INSTR;
        end else if (data_req_i) begin
            gnt_sel_s = GNT_DATA;
        end else if (instr_req_i) begin
            gnt_sel_s = GNT_INSTR;
        end else begin
            gnt_sel_s = GNT_NONE;
        end
    end

    assign instr_gnt_s = (gnt_sel_s == GNT_INSTR);
    assign data_gnt_s  = (gnt_sel_s == GNT_DATA);

    // Steer the winner's fields onto the RAM port; fetches never write, idle cycles drive zeros.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = {BE_WIDTH{1'b0}};
        ram_addr_s  = {ADDR_WIDTH{1'b0}};
        ram_wdata_s = {DATA_WIDTH{1'b0}};
        case (gnt_sel_s)
            GNT_INSTR: begin
                ram_en_s    = 1'b1;
                ram_we_s    = {BE_WIDTH{1'b0}};
                ram_addr_s  = instr_addr_i;
                ram_wdata_s = {DATA_WIDTH{1'b0}};
            end
            GNT_DATA: begin
                ram_en_s    = 1'b1;
                ram_we_s    = data_we_i;
                ram_addr_s  = data_addr_i;
                ram_wdata_s = data_wdata_i;
            end
            default: begin
                ram_en_s    = 1'b0;
                ram_we_s    = {BE_WIDTH{1'b0}};
                ram_addr_s  = {ADDR_WIDTH{1'b0}};
                ram_wdata_s = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Starvation count: grows while fetch waits, saturates at the limit, clears on grant or idle.
    always_comb begin
        starve_next_s = starve_q;
        if (!instr_req_i || instr_gnt_s) begin
            starve_next_s = 4'd0;
        end else if (starve_q < STARVE_MAX) begin
            starve_next_s = starve_q + 4'd1;
        end else begin
            starve_next_s = starve_q;
        end
    end

    // Response owner for next cycle follows this cycle's grant.
    always_comb begin
        resp_next_s = RESP_NONE;
        case (gnt_sel_s)
            GNT_INSTR: resp_next_s = RESP_INSTR;
            GNT_DATA:  resp_next_s = RESP_DATA;
            default:   resp_next_s = RESP_NONE;
        endcase
    end

    // Arbiter state; asynchronous reset drops any pending response immediately.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            resp_q   <= RESP_NONE;
            starve_q <= 4'd0;
        end else begin
            resp_q   <= resp_next_s;
            starve_q <= starve_next_s;
        end
    end

    assign instr_gnt_o    = instr_gnt_s;
    assign data_gnt_o     = data_gnt_s;

    assign ram_en_o       = ram_en_s;
    assign ram_we_o       = ram_we_s;
    assign ram_addr_o     = ram_addr_s;
    assign ram_wdata_o    = ram_wdata_s;

    assign instr_rvalid_o = (resp_q == RESP_INSTR);
    assign data_rvalid_o  = (resp_q == RESP_DATA);
    assign instr_rdata_o  = (resp_q == RESP_INSTR) ? ram_rdata_i : {DATA_WIDTH{1'b0}};
    assign data_rdata_o   = (resp_q == RESP_DATA)  ? ram_rdata_i : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Testbench for jedro_1_mem_arbiter: a byte-writable write-first RAM model
// feeds the DUT, and a transaction-level reference (grant rule, starvation
// count, expected response word from a shadow memory) checks every cycle.
module tb_jedro_1_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rstn;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    jedro_1_mem_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .instr_req_i   (instr_req),
        .instr_addr_i  (instr_addr),
        .instr_gnt_o   (instr_gnt),
        .instr_rvalid_o(instr_rvalid),
        .instr_rdata_o (instr_rdata),
        .data_req_i    (data_req),
        .data_we_i     (data_we),
        .data_addr_i   (data_addr),
        .data_wdata_i  (data_wdata),
        .data_gnt_o    (data_gnt),
        .data_rvalid_o (data_rvalid),
        .data_rdata_o  (data_rdata),
        .ram_en_o      (ram_en),
        .ram_we_o      (ram_we),
        .ram_addr_o    (ram_addr),
        .ram_wdata_o   (ram_wdata),
        .ram_rdata_i   (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // RAM contents seen by the DUT, and the reference's own copy
    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Write-first RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            ram_mem[ram_addr[9:2]] <= merge(ram_mem[ram_addr[9:2]], ram_wdata, ram_we);
            ram_rdata              <= merge(ram_mem[ram_addr[9:2]], ram_wdata, ram_we);
        end
    end

    // Reference state: consecutive denied fetch cycles, pending response owner and word
    int          m_wait  = 0;
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    logic [31:0] m_word  = 32'h0;
    logic        last_ig;
    logic        last_dg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, check, then advance the reference
    task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic [3:0] dwe, input logic [31:0] daddr,
                        input logic [31:0] dwd);
        logic eig;
        logic edg;
        logic [31:0] w;
        @(negedge clk);
        rstn       = rst;
        instr_req  = ireq;
        instr_addr = iaddr;
        data_req   = dreq;
        data_we    = dwe;
        data_addr  = daddr;
        data_wdata = dwd;
        #1;
        if (!rst) begin
            m_wait  = 0;
            m_owner = 0;
        end
        eig = rst && ireq && ((m_wait >= LIMIT) || !dreq);
        edg = rst && dreq && !eig;
        chk("instr_gnt", instr_gnt, eig);
        chk("data_gnt", data_gnt, edg);
        chk("ram_en", ram_en, eig || edg);
        chk("ram_we", ram_we, edg ? dwe : 4'h0);
        chk("ram_addr", ram_addr, eig ? iaddr : (edg ? daddr : 32'h0));
        chk("ram_wdata", ram_wdata, edg ? dwd : 32'h0);
        chk("instr_rvalid", instr_rvalid, m_owner == 1);
        chk("data_rvalid", data_rvalid, m_owner == 2);
        chk("instr_rdata", instr_rdata, (m_owner == 1) ? m_word : 32'h0);
        chk("data_rdata", data_rdata, (m_owner == 2) ? m_word : 32'h0);
        if (eig) begin
            m_word  = ref_mem[iaddr[9:2]];
            m_owner = 1;
        end else if (edg) begin
            w = merge(ref_mem[daddr[9:2]], dwd, dwe);
            ref_mem[daddr[9:2]] = w;
            m_word  = w;
            m_owner = 2;
        end else begin
            m_owner = 0;
        end
        if (!rst || !ireq || eig) m_wait = 0;
        else if (m_wait < LIMIT) m_wait = m_wait + 1;
        last_ig = eig;
        last_dg = edg;
    endtask

    initial begin
        logic        ip;
        logic        dp;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dd;
        logic [3:0]  dw;
        int          fetch_cnt;
        logic [31:0] tmp;

        rstn = 1'b0; instr_req = 1'b0; instr_addr = 32'h0;
        data_req = 1'b0; data_we = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            tmp = $urandom;
            ram_mem[i] = tmp;
            ref_mem[i] = tmp;
        end
        ram_mem[0] = 32'h00E00093; ref_mem[0] = 32'h00E00093;
        ram_mem[1] = 32'h00100113; ref_mem[1] = 32'h00100113;
        ram_mem[2] = 32'h00208193; ref_mem[2] = 32'h00208193;

        // Reset held with both requests high: no grants, no responses
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
        // First grant after release goes to data
        step(1'b1, 1'b1, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
        chk("first_grant_data", {last_dg, last_ig}, 2'b10);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Fetch-only stream
        step(1'b1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("fetch_word1", instr_rdata, 32'h00100113);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("fetch_word2", instr_rdata, 32'h00208193);

        // Data write, read back, byte write, read back
        step(1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h100, 32'h00000021);
        step(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
        chk("write_ack", data_rvalid, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 4'b0010, 32'h100, 32'h0000AB00);
        chk("read_0x100", data_rdata, 32'h00000021);
        step(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("byte_merge", data_rdata, 32'h0000AB21);

        // Contention: fetch wins exactly one cycle in five
        fetch_cnt = 0;
        for (int n = 0; n < 15; n++) begin
            step(1'b1, 1'b1, 32'h8, 1'b1, 4'h0, 32'h200, 32'h0);
            chk("starve_slot", last_ig, (n % 5) == 4);
            if (last_ig) fetch_cnt++;
        end
        chk("fetch_ratio", fetch_cnt, 3);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Response routing with alternating owners
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) step(1'b1, 1'b1, 32'(n * 4), 1'b0, 4'h0, 32'h0, 32'h0);
            else            step(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset right after a data read grant, while fetch has been waiting
        step(1'b1, 1'b1, 32'h4, 1'b1, 4'h0, 32'h100, 32'h0);
        step(1'b1, 1'b1, 32'h4, 1'b1, 4'h0, 32'h100, 32'h0);
        step(1'b0, 1'b1, 32'h4, 1'b1, 4'h0, 32'h100, 32'h0);
        chk("rst_drops_rvalid", data_rvalid, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("no_resp_after_rst", data_rvalid, 1'b0);
        fetch_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 1'b1, 32'h4, 1'b1, 4'h0, 32'h100, 32'h0);
            if (last_ig) fetch_cnt++;
        end
        chk("starve_restart", {fetch_cnt[3:0], last_ig}, 5'b00011);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Randomized traffic with requests held until granted or occasionally withdrawn
        ip = 1'b0; dp = 1'b0; ia = 32'h0; da = 32'h0; dd = 32'h0; dw = 4'h0;
        for (int n = 0; n < 400; n++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1'b1;
                ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end else if (ip && $urandom_range(0, 19) == 0) begin
                ip = 1'b0;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1'b1;
                da = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                dd = $urandom;
                dw = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end else if (dp && $urandom_range(0, 19) == 0) begin
                dp = 1'b0;
            end
            step(1'b1, ip, ia, dp, dw, da, dd);
            if (last_ig) ip = 1'b0;
            if (last_dg) dp = 1'b0;
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jedro_1_mem_arbiter.md
# jedro_1_mem_arbiter

Single-port memory arbiter for the jedro_1 core: shares one byte-writable, 1-cycle-read-latency RAM between the instruction-fetch port and the load/store data port. Sits between jedro_1_top and the bytewrite RAM. It serializes accesses, routes read responses back to the owning requester, and guarantees fetch forward progress through a starvation limit so that misaligned-jump and illegal-instruction tests can run from a unified memory.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; multiple of 8
- ADDR_WIDTH, 32, byte address width
- STARVE_LIMIT, 4, max consecutive cycles fetch may be denied while requesting; range 1..15

Ports:
- clk_i  in  1  clock; all state on rising edge
- rstn_i  in  1  asynchronous, active-low reset
- instr_req_i  in  1  fetch request; held with address until granted
- instr_addr_i  in  ADDR_WIDTH  fetch byte address
- instr_gnt_o  out  1  fetch accepted this cycle
- instr_rvalid_o  out  1  fetch data valid; exactly one cycle after grant
- instr_rdata_o  out  DATA_WIDTH  fetch data
- data_req_i  in  1  data request; held with all fields until granted
- data_we_i  in  DATA_WIDTH/8  byte write enables; all zero = read
- data_addr_i  in  ADDR_WIDTH  data byte address
- data_wdata_i  in  DATA_WIDTH  write data
- data_gnt_o  out  1  data access accepted this cycle
- data_rvalid_o  out  1  data response (read data or write ack); one cycle after grant
- data_rdata_o  out  DATA_WIDTH  load data
- ram_en_o  out  1  RAM access enable
- ram_we_o  out  DATA_WIDTH/8  RAM byte write enables
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid cycle after ram_en_o

## Operation
- Arbitration is combinational each cycle; at most one grant per cycle.
- Default priority: data over fetch (a stalled load/store otherwise blocks the pipeline).
- Starvation counter starve_q (4 bits): +1 each cycle instr_req_i=1 and instr_gnt_o=0, saturating at STARVE_LIMIT; cleared on fetch grant or when instr_req_i=0.
- When starve_q == STARVE_LIMIT and instr_req_i=1, fetch wins over data that cycle.
- Granted requester's fields drive ram_*; ram_en_o = instr_gnt_o | data_gnt_o. Fetch grant forces ram_we_o = 0. No grant: ram_en_o=0, ram_we_o=0, ram_addr_o/ram_wdata_o = 0.
- Response owner register resp_q, states: NONE, INSTR, DATA. Next state = INSTR on fetch grant, DATA on data grant, else NONE. Every cycle is a new decision; back-to-back grants allowed (full throughput).
- instr_rvalid_o = (resp_q==INSTR); data_rvalid_o = (resp_q==DATA), asserted for writes as well as reads.
- instr_rdata_o / data_rdata_o = ram_rdata_i while own rvalid is high, else 0.
- Requester dropping req before grant: no access, no response; not a protocol error.

## Timing
- Reset (async assert, sync-style release on next edge): resp_q=NONE, starve_q=0; all *_gnt_o, *_rvalid_o, ram_en_o, ram_we_o = 0; all data/address outputs 0.
- Grant to rvalid latency: exactly 1 cycle; gnt is same-cycle combinational from req.
- Simultaneous request, starve_q<STARVE_LIMIT: data granted, fetch counter increments.
- Simultaneous request, starve_q==STARVE_LIMIT: fetch granted, counter cleared; data granted next cycle if still requesting.
- Write followed by read of same address on consecutive cycles returns new data (RAM write-first).
- Reset asserted mid-response: pending rvalid dropped immediately; no response after release.

## Test plan
- Reset: hold rstn_i=0 with both reqs high -> all gnt/rvalid/ram_en_o=0; after release first grant goes to data.
- Fetch only: instr_req_i at addr 0x0,0x4,0x8 consecutive cycles, RAM preloaded 0x00E00093,... -> gnt each cycle, instr_rvalid_o one cycle later with matching words, data_rvalid_o never high.
- Data write/read: write 0x00000021 to 0x100 with we=4'b1111, then read 0x100 -> data_rvalid_o after both, read data 0x21 (33); byte write we=4'b0010 of 0x0000AB00 then read -> 0x0000AB21.
- Contention with STARVE_LIMIT=4: both reqs held high continuously -> data granted 4 cycles, fetch on 5th, pattern repeats (fetch exactly 1 in 5 cycles).
- Response routing: alternate fetch grant and data read grant on adjacent cycles -> each rvalid asserts only to the owner, rdata of the other port stays 0.
- Reset mid-operation: assert rstn_i one cycle after a data read grant -> data_rvalid_o never pulses, starve_q restarts at 0.
